// File: rtl/misty_pkg.sv
// -----------------------------------------------------------------------------
// misty_pkg
// Shared widths, default key-schedule latency and the controller state type
// for the MISTY key-schedule control path.
//   KEY_W          : width of a raw cipher key
//   EKEY_W         : width of a complete expanded key set
//   KS_LATENCY_DEF : default cycles from KS valid_i to KS valid_o
//   ks_state_t     : controller FSM states
// -----------------------------------------------------------------------------
package misty_pkg;

    localparam int KEY_W          = 128;
    localparam int EKEY_W         = 256;
    localparam int KS_LATENCY_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // nothing held, ready for a key
        ISSUE = 2'd1,   // one-cycle start pulse towards the key schedule
        WAIT  = 2'd2,   // counting towards the expected KS response
        DONE  = 2'd3    // expanded keys held and valid
    } ks_state_t;

endpackage

// File: rtl/misty_ks_ctrl.sv
// -----------------------------------------------------------------------------
// misty_ks_ctrl
// Accepts a key from a requester, starts an external fixed-latency key
// schedule (KS), checks that the KS answers exactly KS_LATENCY cycles after it
// was started, and holds the resulting expanded keys until cleared or replaced.
//
// Ports
//   clk           : clock, all state changes on its rising edge
//   aresetn       : asynchronous active-low reset
//   req_valid_i   : requester offers req_key_i
//   req_key_i     : key, sampled only on handshake
//   req_ready_o   : controller can take a key (IDLE or DONE), state decode
//   clear_i       : drop held expanded keys (honoured in DONE only)
//   ks_valid_o    : single-cycle start pulse to the KS
//   ks_key_o      : key presented to the KS, stable until the next handshake
//   ks_valid_i    : KS result strobe
//   ks_keys_i     : KS expanded keys
//   keys_valid_o  : keys_o holds a complete expanded key set
//   keys_o        : held expanded keys
//   busy_o        : a KS computation is in flight, state decode
//   err_o         : one-cycle pulse on a missing, early or stray KS strobe
// -----------------------------------------------------------------------------
module misty_ks_ctrl
    import misty_pkg::*;
#(
    parameter int KS_LATENCY = KS_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              req_valid_i,
    input  logic [KEY_W-1:0]  req_key_i,
    output logic              req_ready_o,
    input  logic              clear_i,
    output logic              ks_valid_o,
    output logic [KEY_W-1:0]  ks_key_o,
    input  logic              ks_valid_i,
    input  logic [EKEY_W-1:0] ks_keys_i,
    output logic              keys_valid_o,
    output logic [EKEY_W-1:0] keys_o,
    output logic              busy_o,
    output logic              err_o
);

    // Wide enough to hold KS_LATENCY itself; the counter stops there.
    localparam int              CNT_W   = $clog2(KS_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(KS_LATENCY);

    ks_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             handshake;

    assign req_ready_o = (state_reg == IDLE) || (state_reg == DONE);
    assign busy_o      = (state_reg == ISSUE) || (state_reg == WAIT);
    assign handshake   = req_valid_i && req_ready_o;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            ks_valid_o   <= 1'b0;
            ks_key_o     <= '0;
            keys_valid_o <= 1'b0;
            keys_o       <= '0;
            err_o        <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            ks_valid_o <= 1'b0;
            err_o      <= 1'b0;

            unique case (state_reg)
                IDLE, DONE: begin
                    // A KS strobe with nothing outstanding is a protocol error;
                    // its data is never looked at.
                    if (ks_valid_i) begin
                        err_o <= 1'b1;
                    end
                    // A new key wins over clear_i: go straight to ISSUE.
                    if (handshake) begin
                        ks_key_o     <= req_key_i;
                        ks_valid_o   <= 1'b1;   // high for the ISSUE cycle only
                        keys_valid_o <= 1'b0;
                        state_reg    <= ISSUE;
                    end else if (clear_i && (state_reg == DONE)) begin
                        keys_valid_o <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end

                ISSUE: begin
                    if (ks_valid_i) begin
                        err_o <= 1'b1;
                    end
                    cnt_reg   <= CNT_W'(1);
                    state_reg <= WAIT;
                end

                WAIT: begin
                    if (cnt_reg == LAT_CNT) begin
                        // The only cycle in which the KS may answer.
                        cnt_reg <= '0;
                        if (ks_valid_i) begin
                            keys_o       <= ks_keys_i;
                            keys_valid_o <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            err_o     <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else begin
                        // Early strobe: flag it but keep counting, so the real
                        // answer at the expected cycle is still accepted.
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (ks_valid_i) begin
                            err_o <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_misty_ks_ctrl.sv
// -----------------------------------------------------------------------------
// tb_misty_ks_ctrl
// Bench for misty_ks_ctrl: a behavioural KS stand-in answers LAT cycles after
// each start pulse (or is told to stay silent), stimulus pushes the expected
// outcome of every request into a scoreboard, and a monitor compares each
// output event (KS start, error pulse, keys becoming valid) against it.
// -----------------------------------------------------------------------------
module tb_misty_ks_ctrl;
    import misty_pkg::*;

    localparam int LAT = KS_LATENCY_DEF;

    logic              clk;
    logic              aresetn;
    logic              req_valid_i;
    logic [KEY_W-1:0]  req_key_i;
    logic              req_ready_o;
    logic              clear_i;
    logic              ks_valid_o;
    logic [KEY_W-1:0]  ks_key_o;
    logic              ks_valid_i;
    logic [EKEY_W-1:0] ks_keys_i;
    logic              keys_valid_o;
    logic [EKEY_W-1:0] keys_o;
    logic              busy_o;
    logic              err_o;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // Expected controller outcome: an error pulse or keys becoming valid.
    typedef struct {
        bit                is_err;
        int                at;
        logic [EKEY_W-1:0] keys;
    } exp_t;
    exp_t exp_q[$];

    // Expected KS start pulse.
    typedef struct {
        int               at;
        logic [KEY_W-1:0] key;
    } ksv_t;
    ksv_t ksv_q[$];

    logic [EKEY_W-1:0] sched[int];   // KS answers, keyed by cycle
    bit                spur[int];    // injected stray KS strobes, keyed by cycle
    bit                withhold = 1'b0;

    misty_ks_ctrl #(.KS_LATENCY(LAT)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .req_valid_i  (req_valid_i),
        .req_key_i    (req_key_i),
        .req_ready_o  (req_ready_o),
        .clear_i      (clear_i),
        .ks_valid_o   (ks_valid_o),
        .ks_key_o     (ks_key_o),
        .ks_valid_i   (ks_valid_i),
        .ks_keys_i    (ks_keys_i),
        .keys_valid_o (keys_valid_o),
        .keys_o       (keys_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in key schedule result: any fixed, key-dependent mapping will do.
    function automatic logic [EKEY_W-1:0] ks_golden(input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] rot;
        rot = {k[63:0], k[127:64]};
        return {k ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969, rot + 128'd1};
    endfunction

    function automatic logic [KEY_W-1:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [EKEY_W-1:0] act,
                       input logic [EKEY_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // KS model: remembers each start pulse and answers LAT cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                sched.delete();
            end else if (ks_valid_o && !withhold) begin
                sched[cyc + LAT] = ks_golden(ks_key_o);
            end
        end
    end

    // KS strobe driver: scheduled answers plus injected stray strobes with junk.
    initial begin
        ks_valid_i = 1'b0;
        ks_keys_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sched.exists(cyc)) begin
                ks_valid_i = 1'b1;
                ks_keys_i  = sched[cyc];
            end else if (spur.exists(cyc)) begin
                ks_valid_i = 1'b1;
                ks_keys_i  = {8{$urandom()}};
            end else begin
                ks_valid_i = 1'b0;
                ks_keys_i  = {8{$urandom()}};
            end
        end
    end

    task automatic got_event(input bit is_err);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d got=%s want=none", cyc,
                     is_err ? "err" : "keys");
        end else begin
            e = exp_q.pop_front();
            if (e.is_err !== is_err || e.at != cyc || (!is_err && keys_o !== e.keys)) begin
                bad++;
                $display("FAIL txn got=(err=%0b cyc=%0d keys=%h) want=(err=%0b cyc=%0d keys=%h)",
                         is_err, cyc, keys_o, e.is_err, e.at, e.keys);
            end else begin
                $display("txn cyc=%0d %s ok keys=%h", cyc, is_err ? "err" : "keys", keys_o);
            end
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboards.
    initial begin
        bit                prev_kv  = 1'b0;
        bit                rst_prev = 1'b1;
        logic [EKEY_W-1:0] prev_keys = '0;
        ksv_t              s;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prev_kv   = keys_valid_o;
                prev_keys = keys_o;
                rst_prev  = 1'b1;
                continue;
            end
            if (ks_valid_o) begin
                total++;
                if (ksv_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ks_valid cyc=%0d got=1 want=0", cyc);
                end else begin
                    s = ksv_q.pop_front();
                    if (s.at != cyc || ks_key_o !== s.key) begin
                        bad++;
                        $display("FAIL ks_start got=(cyc=%0d key=%h) want=(cyc=%0d key=%h)",
                                 cyc, ks_key_o, s.at, s.key);
                    end else begin
                        $display("txn cyc=%0d ks_start ok key=%h", cyc, ks_key_o);
                    end
                end
            end
            if (err_o) got_event(1'b1);
            if (keys_valid_o && !prev_kv) got_event(1'b0);
            if (!rst_prev) begin
                total++;
                if (keys_o !== prev_keys && !(keys_valid_o && !prev_kv)) begin
                    bad++;
                    $display("FAIL keys_stable cyc=%0d got=%h want=%h", cyc, keys_o, prev_keys);
                end
            end
            prev_kv   = keys_valid_o;
            prev_keys = keys_o;
            rst_prev  = 1'b0;
        end
    end

    // Call at posedge+1. mode 0: KS answers, 1: KS silent, 2: stray strobe at T+k.
    task automatic send_req(input logic [KEY_W-1:0] key, input int mode, input int k,
                            input bit with_clear, output int t_hs);
        bit got = 1'b0;
        t_hs        = -1;
        withhold    = (mode == 1);
        req_valid_i = 1'b1;
        req_key_i   = key;
        clear_i     = with_clear;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL hs_timeout cyc=%0d got=no_ready want=ready", cyc);
        end else begin
            t_hs = cyc;
            ksv_q.push_back('{t_hs + 1, key});
            if (mode == 2) begin
                spur[t_hs + k] = 1'b1;
                exp_q.push_back('{1'b1, t_hs + k + 1, '0});
            end
            if (mode == 1) exp_q.push_back('{1'b1, t_hs + LAT + 2, '0});
            else           exp_q.push_back('{1'b0, t_hs + LAT + 2, ks_golden(key)});
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        clear_i     = 1'b0;
        req_key_i   = rand_key();
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stray KS strobe while nothing is outstanding (IDLE or DONE).
    task automatic spur_now();
        int c = cyc;
        spur[c + 1] = 1'b1;
        exp_q.push_back('{1'b1, c + 2, '0});
        repeat (3) @(posedge clk);
        #1;
    endtask

    // clear_i alone in DONE.
    task automatic clear_only();
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        @(negedge clk);
        chk("clear_kv", keys_valid_o, 0);
        chk("clear_ready", req_ready_o, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t, t2, c, r, mode, k;
        bit in_done;
        aresetn     = 1'b0;
        req_valid_i = 1'b0;
        clear_i     = 1'b0;
        req_key_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ks_valid", ks_valid_o, 0);
        chk("rst_ks_key", ks_key_o, 0);
        chk("rst_keys_valid", keys_valid_o, 0);
        chk("rst_keys", keys_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", req_ready_o, 1);

        // Golden key; first handshake on the first edge after release.
        aresetn = 1'b1;
        c = cyc;
        send_req(128'h00112233_44556677_8899aabb_ccddeeff, 0, 0, 1'b0, t);
        chk("first_hs", t, c);
        chk("issue_busy", busy_o, 1);

        // Second request held from T+3 is taken only in DONE at T+10.
        repeat (2) @(posedge clk);
        #1;
        send_req(rand_key(), 0, 0, 1'b0, t2);
        chk("held_hs", t2, t + 10);
        @(negedge clk);
        chk("held_kv_drop", keys_valid_o, 0);
        chk("held_ready", req_ready_o, 0);
        wait_cycle(t2 + LAT + 2);

        // KS stays silent: error at T+10, back to IDLE.
        send_req(rand_key(), 1, 0, 1'b0, t);
        wait_cycle(t + LAT + 2);
        @(negedge clk);
        chk("to_err", err_o, 1);
        chk("to_ready", req_ready_o, 1);
        chk("to_kv", keys_valid_o, 0);
        chk("to_busy", busy_o, 0);
        @(posedge clk);
        #1;

        // Stray strobe in IDLE, then one at T+5 during a good computation.
        spur_now();
        send_req(rand_key(), 2, 5, 1'b0, t);
        wait_cycle(t + LAT + 2);

        // Reset at T+4 abandons the computation silently.
        send_req(rand_key(), 0, 0, 1'b0, t);
        wait_cycle(t + 4);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_ks_valid", ks_valid_o, 0);
        chk("arst_ks_key", ks_key_o, 0);
        chk("arst_kv", keys_valid_o, 0);
        chk("arst_keys", keys_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_busy", busy_o, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send_req(rand_key(), 0, 0, 1'b0, t);
        wait_cycle(t + LAT + 2);

        // clear_i with a new request in DONE: no IDLE cycle in between.
        c = cyc;
        send_req(rand_key(), 0, 0, 1'b1, t);
        chk("clr_hs", t, c);
        wait_cycle(t + LAT + 2);
        clear_only();

        // Randomized traffic.
        in_done = 1'b0;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) spur_now();
            if (r == 1 && in_done) begin
                clear_only();
                in_done = 1'b0;
            end
            mode = $urandom_range(0, 2);
            k    = $urandom_range(1, LAT);
            c    = cyc;
            send_req(rand_key(), mode, k, in_done && ($urandom_range(0, 1) == 1), t);
            chk("rnd_hs", t, c);
            wait_cycle(t + LAT + 2);
            in_done = (mode != 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 0);
        chk("ksv_q_empty", ksv_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/misty_ks_ctrl.md
MISTY_KS_CTRL -- requirements
Module: misty_ks_ctrl

Interface
REQ-001 SHALL have parameter KS_LATENCY, default 8, cycles from the KS valid_i pulse to the KS valid_o pulse.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid_i  input  1  requester offers a new 128-bit key.
REQ-005 SHALL have port req_key_i  input  128  key; sampled only on handshake.
REQ-006 SHALL have port req_ready_o  output  1  controller can accept a key this cycle.
REQ-007 SHALL have port clear_i  input  1  invalidate held expanded keys.
REQ-008 SHALL have port ks_valid_o  output  1  drives KS valid_i; single-cycle pulse.
REQ-009 SHALL have port ks_key_o  output  128  drives KS key_i.
REQ-010 SHALL have port ks_valid_i  input  1  from KS valid_o.
REQ-011 SHALL have port ks_keys_i  input  256  from KS expand_keys_o.
REQ-012 SHALL have port keys_valid_o  output  1  keys_o holds a complete expanded key set.
REQ-013 SHALL have port keys_o  output  256  held expanded keys.
REQ-014 SHALL have port busy_o  output  1  a KS computation is in flight.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse on a protocol or latency violation.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-017 SHALL drive req_ready_o = 1 only in IDLE and DONE, with no dependence on req_valid_i.
REQ-018 SHALL, on handshake at cycle T, register ks_key_o <= req_key_i, enter ISSUE, and drop keys_valid_o at T+1.
REQ-019 SHALL assert ks_valid_o only in ISSUE (cycle T+1, exactly one cycle), then enter WAIT with the latency counter at 1.
REQ-020 SHALL hold ks_key_o stable from T+1 until the next handshake.
REQ-021 SHALL, in WAIT, increment the counter each cycle and require ks_valid_i exactly when counter == KS_LATENCY (cycle T+1+KS_LATENCY).
REQ-022 SHALL, on ks_valid_i at the expected cycle, capture ks_keys_i into keys_o, enter DONE, and assert keys_valid_o from the next cycle.
REQ-023 SHALL, if ks_valid_i is absent at counter == KS_LATENCY, pulse err_o the next cycle, return to IDLE, and leave keys_valid_o = 0.
REQ-024 SHALL, on ks_valid_i in ISSUE, in WAIT before the expected count, in IDLE or in DONE, pulse err_o the next cycle and ignore ks_keys_i, with the state otherwise unchanged.
REQ-025 SHALL assert busy_o in ISSUE and WAIT only.
REQ-026 SHALL, on clear_i in DONE, clear keys_valid_o next cycle and enter IDLE.
REQ-027 SHALL ignore clear_i in IDLE, ISSUE and WAIT.
REQ-028 SHALL let a handshake take priority over clear_i in the same cycle (DONE -> ISSUE).
REQ-029 SHALL size the latency counter to $clog2(KS_LATENCY+1) bits and never let it wrap.
REQ-030 SHALL keep keys_o unchanged except on a valid capture.
REQ-031 SHALL register all outputs except req_ready_o and busy_o, which decode from the state only.

Reset
REQ-032 SHALL, on aresetn low, immediately set state = IDLE, counter = 0, ks_valid_o = 0, keys_valid_o = 0, err_o = 0, ks_key_o = 0 and keys_o = 0.
REQ-033 SHALL, on reset mid-ISSUE or mid-WAIT, abandon the computation with no err_o pulse after release.
REQ-034 SHALL produce the first possible handshake on the first posedge after aresetn rises.

Structure
REQ-035 SHALL take KEY_W = 128, EKEY_W = 256, KS_LATENCY_DEF = 8 and the state enum type from shared package misty_pkg.
REQ-036 SHALL contain no sub-module; the KS instance and its wiring belong to the parent.

Verification
REQ-037 SHALL cover this scenario: key 0x00112233_44556677_8899aabb_ccddeeff accepted at T -> ks_valid_o high only at T+1, KS returns at T+9, keys_valid_o = 1 from T+10, keys_o equals the KS golden value.
REQ-038 SHALL cover this scenario: second req_valid_i held at T+3 -> req_ready_o = 0 until DONE, accepted at T+10, keys_valid_o = 0 at T+11, new keys at T+20.
REQ-039 SHALL cover this scenario: model withholds ks_valid_i -> err_o pulse at T+10, state IDLE, keys_valid_o = 0, req_ready_o = 1.
REQ-040 SHALL cover this scenario: spurious ks_valid_i in IDLE and at T+5 -> err_o pulses next cycle, keys_o unchanged, correct capture at T+9 still succeeds.
REQ-041 SHALL cover this scenario: aresetn low at T+4 -> all outputs 0 immediately, no err_o after release, new request completes normally.
REQ-042 SHALL cover this scenario: clear_i and req_valid_i together in DONE -> new computation starts with no extra IDLE cycle; clear_i alone -> keys_valid_o = 0 next cycle.
